wb_regfile: RTL and testbench

WB_REGFILE -- requirements
Module: wb_regfile

---
 rtl/wb_regfile.sv | 86 ++++++++
 tb/tb_wb_regfile.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// 31x64 integer register file with a pending-write scoreboard for RAW stalls.
// Define REGFILE_BYPASS_EN to forward same-cycle write-back data to the read ports.
module wb_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] wb_data_i,
  input  logic [4:0]  wb_addr_i,
  input  logic        wb_we_i,
  input  logic [4:0]  rs1_addr_i,
  input  logic [4:0]  rs2_addr_i,
  output logic [63:0] rs1_data_o,
  output logic [63:0] rs2_data_o,
  input  logic        issue_valid_i,
  input  logic        issue_we_i,
  input  logic [4:0]  issue_rd_i,
  input  logic        flush_i,
  output logic        hazard_o
);

  logic [63:0] regs_q [1:31];
  logic [63:0] regs_d [1:31];
  logic [31:1] pending_q;
  logic [31:1] pending_d;

  logic [31:0] pending_ext;
  logic        wb_fire;
  logic        issue_fire;
  logic        byp1;
  logic        byp2;
  logic [63:0] stored1;
  logic [63:0] stored2;
  logic        haz1;
  logic        haz2;

  assign wb_fire     = wb_we_i && (wb_addr_i != 5'd0);
  assign pending_ext = {pending_q, 1'b0};

`ifdef REGFILE_BYPASS_EN
  assign byp1 = wb_fire && (wb_addr_i == rs1_addr_i);
  assign byp2 = wb_fire && (wb_addr_i == rs2_addr_i);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  assign stored1 = (rs1_addr_i == 5'd0) ? 64'd0 : regs_q[rs1_addr_i];
  assign stored2 = (rs2_addr_i == 5'd0) ? 64'd0 : regs_q[rs2_addr_i];

  assign rs1_data_o = byp1 ? wb_data_i : stored1;
  assign rs2_data_o = byp2 ? wb_data_i : stored2;

  // Bit 0 of pending_ext is tied low, so x0 can never report a hazard.
  assign haz1     = pending_ext[rs1_addr_i] && !byp1;
  assign haz2     = pending_ext[rs2_addr_i] && !byp2;
  assign hazard_o = haz1 || haz2;

  assign issue_fire = issue_valid_i && !hazard_o && issue_we_i && (issue_rd_i != 5'd0);

  always_comb begin
    regs_d    = regs_q;
    pending_d = pending_q;
    if (wb_fire) begin
      regs_d[wb_addr_i]    = wb_data_i;
      pending_d[wb_addr_i] = 1'b0;
    end
    // Set after clear: the issuing instruction is newer than the one retiring.
    if (issue_fire) begin
      pending_d[issue_rd_i] = 1'b1;
    end
    if (flush_i) begin
      pending_d = '0;
    end
    if (rst) begin
      for (int i = 1; i < 32; i++) begin
        regs_d[i] = 64'd0;
      end
      pending_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    regs_q    <= regs_d;
    pending_q <= pending_d;
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile: reset, x0, RAW stall,
// set/clear collision, flush and stalled-issue scenarios.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] wb_data_i;
  logic [4:0]  wb_addr_i;
  logic        wb_we_i;
  logic [4:0]  rs1_addr_i;
  logic [4:0]  rs2_addr_i;
  logic [63:0] rs1_data_o;
  logic [63:0] rs2_data_o;
  logic        issue_valid_i;
  logic        issue_we_i;
  logic [4:0]  issue_rd_i;
  logic        flush_i;
  logic        hazard_o;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk           (clk),
    .rst           (rst),
    .wb_data_i     (wb_data_i),
    .wb_addr_i     (wb_addr_i),
    .wb_we_i       (wb_we_i),
    .rs1_addr_i    (rs1_addr_i),
    .rs2_addr_i    (rs2_addr_i),
    .rs1_data_o    (rs1_data_o),
    .rs2_data_o    (rs2_data_o),
    .issue_valid_i (issue_valid_i),
    .issue_we_i    (issue_we_i),
    .issue_rd_i    (issue_rd_i),
    .flush_i       (flush_i),
    .hazard_o      (hazard_o)
  );

  task automatic applyStimulus(input logic we, input logic [4:0] waddr, input logic [63:0] wdata,
                               input logic iv, input logic [4:0] ird, input logic fl,
                               input logic [4:0] r1, input logic [4:0] r2);
    wb_we_i       = we;
    wb_addr_i     = waddr;
    wb_data_i     = wdata;
    issue_valid_i = iv;
    issue_we_i    = iv;
    issue_rd_i    = ird;
    flush_i       = fl;
    rs1_addr_i    = r1;
    rs2_addr_i    = r2;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
    tick();

    // Write attempted under reset must be discarded.
    applyStimulus(1'b1, 5'd5, 64'h1234, 1'b1, 5'd6, 1'b0, 5'd0, 5'd0);
    tick();
    rst = 1'b0;
    applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 1'b0, 5'd5, 5'd6);
    checkOutput("reset_x5_data", rs1_data_o, 64'd0);
    checkOutput("reset_x6_data", rs2_data_o, 64'd0);
    checkOutput("reset_hazard", {63'd0, hazard_o}, 64'd0);

    // Plain write-back then read on both ports.
    applyStimulus(1'b1, 5'd5, 64'h1234, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
    tick();
    applyStimulus(1'b1, 5'd6, 64'hDEAD_BEEF_0000_1111, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 1'b0, 5'd5, 5'd6);
    checkOutput("write_x5", rs1_data_o, 64'h1234);
    checkOutput("write_x6", rs2_data_o, 64'hDEAD_BEEF_0000_1111);

    // x0 ignores writes and never becomes pending.
    applyStimulus(1'b1, 5'd0, 64'hFFFF, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
    checkOutput("x0_read", rs1_data_o, 64'd0);
    applyStimulus(1'b0, 5'd0, 64'd0, 1'b1, 5'd0, 1'b0, 5'd0, 5'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
    checkOutput("x0_hazard", {63'd0, hazard_o}, 64'd0);

    // RAW stall on x7.
    applyStimulus(1'b0, 5'd0, 64'd0, 1'b1, 5'd7, 1'b0, 5'd0, 5'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd7);
    checkOutput("raw_hazard_c1", {63'd0, hazard_o}, 64'd1);
    tick();
    checkOutput("raw_hazard_c2", {63'd0, hazard_o}, 64'd1);
    applyStimulus(1'b1, 5'd7, 64'hABCD, 1'b0, 5'd0, 1'b0, 5'd0, 5'd7);
`ifdef REGFILE_BYPASS_EN
    checkOutput("raw_wb_hazard", {63'd0, hazard_o}, 64'd0);
    checkOutput("raw_wb_data", rs2_data_o, 64'hABCD);
`else
    checkOutput("raw_wb_hazard", {63'd0, hazard_o}, 64'd1);
    checkOutput("raw_wb_data", rs2_data_o, 64'd0);
`endif
    tick();
    applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd7);
    checkOutput("raw_after_hazard", {63'd0, hazard_o}, 64'd0);
    checkOutput("raw_after_data", rs2_data_o, 64'hABCD);

    // Same-cycle clear and set of x3: set wins.
    applyStimulus(1'b0, 5'd0, 64'd0, 1'b1, 5'd3, 1'b0, 5'd0, 5'd0);
    tick();
    applyStimulus(1'b1, 5'd3, 64'h33, 1'b1, 5'd3, 1'b0, 5'd0, 5'd0);
    checkOutput("setclr_accept", {63'd0, hazard_o}, 64'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 1'b0, 5'd3, 5'd0);
    checkOutput("setclr_hazard", {63'd0, hazard_o}, 64'd1);
    checkOutput("setclr_data", rs1_data_o, 64'h33);

    // Flush with a same-cycle issue and a same-cycle write-back.
    applyStimulus(1'b0, 5'd0, 64'd0, 1'b1, 5'd4, 1'b0, 5'd0, 5'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 64'd0, 1'b1, 5'd9, 1'b0, 5'd0, 5'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 1'b0, 5'd4, 5'd9);
    checkOutput("preflush_hazard", {63'd0, hazard_o}, 64'd1);
    applyStimulus(1'b1, 5'd20, 64'h2020, 1'b1, 5'd12, 1'b1, 5'd0, 5'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 1'b0, 5'd4, 5'd0);
    checkOutput("flush_x4", {63'd0, hazard_o}, 64'd0);
    applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 1'b0, 5'd9, 5'd0);
    checkOutput("flush_x9", {63'd0, hazard_o}, 64'd0);
    applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 1'b0, 5'd12, 5'd3);
    checkOutput("flush_x12_x3", {63'd0, hazard_o}, 64'd0);
    applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd20);
    checkOutput("flush_write_x20", rs2_data_o, 64'h2020);

    // Issue attempted while stalled must not claim its destination.
    applyStimulus(1'b0, 5'd0, 64'd0, 1'b1, 5'd8, 1'b0, 5'd0, 5'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 64'd0, 1'b1, 5'd10, 1'b0, 5'd8, 5'd0);
    checkOutput("stall_hazard", {63'd0, hazard_o}, 64'd1);
    tick();
    applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 1'b0, 5'd10, 5'd0);
    checkOutput("stall_x10_clear", {63'd0, hazard_o}, 64'd0);
    applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 1'b0, 5'd8, 5'd0);
    checkOutput("stall_x8_pending", {63'd0, hazard_o}, 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
